mux4_arbiter: RTL and testbench

MUX4_ARBITER -- requirements
Module: mux4_arbiter

---
 rtl/mux4_arbiter.sv | 103 ++++++++++
 tb/tb_mux4_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_arbiter.sv
// Four-input round-robin arbiter feeding a single registered output word with valid/ready handshake.
// Optional build macro MUX4_ARB_LOCK_EN adds a Lock input that lets the current owner keep the grant.
module mux4_arbiter #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic [3:0]   Req,
    input  logic [W-1:0] D0,
    input  logic [W-1:0] D1,
    input  logic [W-1:0] D2,
    input  logic [W-1:0] D3,
`ifdef MUX4_ARB_LOCK_EN
    input  logic [3:0]   Lock,
`else
`endif
    input  logic         Ready,
    output logic [3:0]   Ack,
    output logic [1:0]   Sel,
    output logic [W-1:0] O,
    output logic         Valid
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   o_q, o_d;
    logic [1:0]     sel_q, sel_d;
    logic [1:0]     last_q, last_d;
    logic [3:0]     ack_d;
    logic [1:0]     win;
    logic           cap_opp;

    // First set request bit searched from last+1 up to last+4 (i.e. last itself).
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [W-1:0] dmux(input logic [1:0] s, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] c,
                                          input logic [W-1:0] d);
        case (s)
            2'd0:    dmux = a;
            2'd1:    dmux = b;
            2'd2:    dmux = c;
            default: dmux = d;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        sel_d   = sel_q;
        last_d  = last_q;
        ack_d   = 4'b0000;
        win     = rr_pick(Req, last_q);
`ifdef MUX4_ARB_LOCK_EN
        if (state_q == BUSY && Lock[sel_q] && Req[sel_q]) win = sel_q;
`else
`endif
        cap_opp = (state_q == IDLE) || Ready;
        if (cap_opp) begin
            if (|Req) begin
                ack_d   = 4'b0001 << win;
                o_d     = dmux(win, D0, D1, D2, D3);
                sel_d   = win;
                last_d  = win;
                state_d = BUSY;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Ack is combinational, so it must be masked directly while reset is held.
    assign Ack   = Rst_n ? ack_d : 4'b0000;
    assign Sel   = sel_q;
    assign O     = o_q;
    assign Valid = (state_q == BUSY);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            o_q     <= '0;
            sel_q   <= 2'b00;
            last_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed bench for mux4_arbiter: expected words queued at capture, compared when transferred.
module tb_mux4_arbiter;

    localparam int W = 8;

    logic         Clk;
    logic         Rst_n;
    logic [3:0]   Req;
    logic [W-1:0] d [4];
    logic         Ready;
    logic [3:0]   Ack;
    logic [1:0]   Sel;
    logic [W-1:0] O;
    logic         Valid;
`ifdef MUX4_ARB_LOCK_EN
    logic [3:0]   Lock;
`else
`endif

    int checks = 0;
    int errors = 0;
    logic [W+1:0] sbq [$];

    mux4_arbiter #(.W(W)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Req   (Req),
        .D0    (d[0]),
        .D1    (d[1]),
        .D2    (d[2]),
        .D3    (d[3]),
`ifdef MUX4_ARB_LOCK_EN
        .Lock  (Lock),
`else
`endif
        .Ready (Ready),
        .Ack   (Ack),
        .Sel   (Sel),
        .O     (O),
        .Valid (Valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] a);
        oh2idx = 0;
        for (int i = 0; i < 4; i++) if (a[i]) oh2idx = i;
    endfunction

    // Sample at the falling edge: retire a transfer, check Ack, queue the newly captured word.
    task automatic sample(input logic [3:0] exp_ack);
        logic [W+1:0] item;
        int w;
        @(negedge Clk);
        if (Valid && Ready) begin
            chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                item = sbq.pop_front();
                chk("sb_data", 32'(O), 32'(item[W+1:2]));
                chk("sb_sel", 32'(Sel), 32'(item[1:0]));
            end
        end
        chk("ack", 32'(Ack), 32'(exp_ack));
        if (exp_ack != 4'b0000) begin
            w = oh2idx(exp_ack);
            sbq.push_back({d[w], 2'(w)});
        end
    endtask

    task automatic adv();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [3:0] rot [5];
        logic [3:0] e;
        rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000; rot[4] = 4'b0001;

        Rst_n = 1'b0;
        Req   = 4'b1111;
        Ready = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = '0;
`ifdef MUX4_ARB_LOCK_EN
        Lock = 4'b0000;
`else
`endif
        repeat (2) @(posedge Clk);
        #1;

        // Reset state with requests pending
        sample(4'b0000);
        chk("rst_valid", 32'(Valid), 32'd0);
        chk("rst_o", 32'(O), 32'h00);
        chk("rst_sel", 32'(Sel), 32'd0);
        adv();

        // Single requester
        Rst_n = 1'b1;
        Req   = 4'b0001;
        d[0]  = 8'hA5;
        sample(4'b0001);
        adv();
        Req = 4'b0000;
        sample(4'b0000);
        chk("single_valid", 32'(Valid), 32'd1);
        chk("single_o", 32'(O), 32'hA5);
        chk("single_sel", 32'(Sel), 32'd0);
        adv();
        sample(4'b0000);
        chk("single_idle", 32'(Valid), 32'd0);
        adv();

        // All requesting from a fresh reset
        Rst_n = 1'b0;
        adv();
        Rst_n = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 8'(8'h10 + i);
        Req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            sample(rot[i]);
            adv();
        end
        sample(4'b0010);
        adv();

        // Backpressure holding word 11 while Req wiggles
        Ready = 1'b0;
        Req   = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            sample(4'b0000);
            chk("bp_o", 32'(O), 32'h11);
            chk("bp_sel", 32'(Sel), 32'd1);
            chk("bp_valid", 32'(Valid), 32'd1);
            adv();
        end
        Ready = 1'b1;
        Req   = 4'b1111;
        sample(4'b0100);
        adv();
        sample(4'b1000);
        adv();

        // Wrap-around after grant to 3
        Req = 4'b1001;
        sample(4'b0001);
        adv();
        Req = 4'b0000;
        sample(4'b0000);
        chk("wrap_sel", 32'(Sel), 32'd0);
        chk("wrap_valid", 32'(Valid), 32'd1);
        adv();
        sample(4'b0000);
        chk("wrap_idle", 32'(Valid), 32'd0);
        adv();

        // Lone requester equal to last wins again
        Req  = 4'b0001;
        d[0] = 8'h5A;
        sample(4'b0001);
        adv();
        sample(4'b0001);
        adv();

        // Two requesters with owner 0 holding the grant
        Req = 4'b0011;
`ifdef MUX4_ARB_LOCK_EN
        Lock = 4'b0001;
`else
`endif
        for (int i = 0; i < 4; i++) begin
`ifdef MUX4_ARB_LOCK_EN
            e = 4'b0001;
`else
            e = (i % 2 == 0) ? 4'b0010 : 4'b0001;
`endif
            sample(e);
            adv();
        end
        Req = 4'b0000;
`ifdef MUX4_ARB_LOCK_EN
        Lock = 4'b0000;
`else
`endif
        sample(4'b0000);
        adv();
        sample(4'b0000);
        adv();

        // Reset asserted while a word is held
        Req  = 4'b0100;
        d[2] = 8'h3C;
        sample(4'b0100);
        adv();
        Ready = 1'b0;
        Req   = 4'b0001;
        sample(4'b0000);
        chk("pre_rst_o", 32'(O), 32'h3C);
        chk("pre_rst_valid", 32'(Valid), 32'd1);
        chk("pre_rst_sel", 32'(Sel), 32'd2);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(Valid), 32'd0);
        chk("async_rst_o", 32'(O), 32'h00);
        chk("async_rst_sel", 32'(Sel), 32'd0);
        chk("async_rst_ack", 32'(Ack), 32'd0);
        sbq.delete();
        @(posedge Clk);
        #1;

        // Priority restarts at requester 0 side after reset
        Rst_n = 1'b1;
        Ready = 1'b1;
        Req   = 4'b1010;
        sample(4'b0010);
        chk("post_rst_valid", 32'(Valid), 32'd0);
        adv();
        Req = 4'b0000;
        sample(4'b0000);
        chk("post_rst_o", 32'(O), 32'h11);
        adv();
        sample(4'b0000);
        adv();

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
